// File: rtl/fp_pkg.sv
// Shared widths, exponent saturation value and state/op encodings for the
// floating-point post-add normalizer.
package fp_pkg;
  localparam int MANT_W = 7;
  localparam int EXP_W  = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    EOP_HOLD     = 3'd0,
    EOP_LOAD     = 3'd1,
    EOP_LOAD_INC = 3'd2,
    EOP_DEC      = 3'd3,
    EOP_CLR      = 3'd4
  } exp_op_e;
endpackage

// File: rtl/norm_exp_step.sv
// Registered exponent with load / load+1 / -1 / clear steps and look-ahead
// detection of the +1 result hitting all-ones and the -1 result hitting zero.
module norm_exp_step #(
  parameter int EXP_W = fp_pkg::EXP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  fp_pkg::exp_op_e   op,
  input  logic [EXP_W-1:0]  d,
  output logic [EXP_W-1:0]  e,
  output logic              inc_ovf,
  output logic              dec_unf
);
  import fp_pkg::*;

  localparam logic [EXP_W-1:0] EMAX = {EXP_W{1'b1}};

  logic [EXP_W-1:0] inc_val;
  logic [EXP_W-1:0] dec_val;

  assign inc_val = d + 1'b1;
  assign dec_val = e - 1'b1;
  assign inc_ovf = (inc_val == EMAX);
  assign dec_unf = (dec_val == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e <= '0;
    end else begin
      case (op)
        EOP_LOAD:     e <= d;
        EOP_LOAD_INC: e <= inc_val;
        EOP_DEC:      e <= dec_val;
        EOP_CLR:      e <= '0;
        default:      e <= e;
      endcase
    end
  end
endmodule

// File: rtl/fp_normalize.sv
// Normalizes a raw mantissa sum: one-bit right shift on carry, iterative
// left shift until the hidden bit is set, with zero/overflow/underflow flags.
module fp_normalize #(
  parameter int MANT_W = fp_pkg::MANT_W,
  parameter int EXP_W  = fp_pkg::EXP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W+1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf
);
  import fp_pkg::*;

  state_e            state, state_nxt;
  logic [MANT_W+1:0] m, m_nxt;
  logic              s, s_nxt;
  logic              zero_f, zero_nxt;
  logic              ovf_f, ovf_nxt;
  logic              unf_f, unf_nxt;
  exp_op_e           eop;
  logic [EXP_W-1:0]  e;
  logic              inc_ovf;
  logic              dec_unf;

  norm_exp_step #(.EXP_W(EXP_W)) u_exp (
    .clk     (clk),
    .reset_n (reset_n),
    .op      (eop),
    .d       (in_exp),
    .e       (e),
    .inc_ovf (inc_ovf),
    .dec_unf (dec_unf)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sign  = s;
  assign out_exp   = e;
  assign out_mant  = m[MANT_W-1:0];
  assign out_zero  = zero_f;
  assign out_ovf   = ovf_f;
  assign out_unf   = unf_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      m      <= '0;
      s      <= 1'b0;
      zero_f <= 1'b0;
      ovf_f  <= 1'b0;
      unf_f  <= 1'b0;
    end else begin
      state  <= state_nxt;
      m      <= m_nxt;
      s      <= s_nxt;
      zero_f <= zero_nxt;
      ovf_f  <= ovf_nxt;
      unf_f  <= unf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    m_nxt     = m;
    s_nxt     = s;
    zero_nxt  = zero_f;
    ovf_nxt   = ovf_f;
    unf_nxt   = unf_f;
    eop       = EOP_HOLD;
    case (state)
      IDLE: begin
        if (in_valid) begin
          s_nxt    = in_sign;
          zero_nxt = 1'b0;
          ovf_nxt  = 1'b0;
          unf_nxt  = 1'b0;
          state_nxt = DONE;
          if (in_mant == '0) begin
            m_nxt    = '0;
            eop      = EOP_CLR;
            zero_nxt = 1'b1;
          end else if (in_mant[MANT_W+1]) begin
            // Carry: shift right once, dropping the LSB (truncation).
            eop = EOP_LOAD_INC;
            if (inc_ovf) begin
              ovf_nxt = 1'b1;
              m_nxt   = '0;
            end else begin
              m_nxt = in_mant >> 1;
            end
          end else if (in_exp == '0) begin
            unf_nxt  = 1'b1;
            zero_nxt = 1'b1;
            m_nxt    = '0;
            eop      = EOP_CLR;
          end else begin
            m_nxt     = in_mant;
            eop       = EOP_LOAD;
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (m[MANT_W]) begin
          state_nxt = DONE;
        end else if (dec_unf) begin
          // Exponent would reach zero before the hidden bit is set.
          unf_nxt   = 1'b1;
          zero_nxt  = 1'b1;
          m_nxt     = '0;
          eop       = EOP_CLR;
          state_nxt = DONE;
        end else begin
          m_nxt = m << 1;
          eop   = EOP_DEC;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fp_normalize.sv
// Directed and random checks of fp_normalize against an arithmetic reference
// model of normalization (MANT_W=7, EXP_W=8).
module tb_fp_normalize;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sign = 1'b0;
  logic [7:0] in_exp = '0;
  logic [8:0] in_mant = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_sign;
  logic [7:0] out_exp;
  logic [6:0] out_mant;
  logic       out_zero, out_ovf, out_unf;

  int checks = 0;
  int errors = 0;

  fp_normalize dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_mant(out_mant),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: value of the normalized number computed directly from the
  // leading-one position, plus the cycle count the handshake rules imply.
  task automatic model(input logic [7:0] ex, input logic [8:0] mt,
                       output logic [7:0] oe, output logic [6:0] om,
                       output logic z, output logic o, output logic u,
                       output int lat);
    logic [8:0] tmp;
    int p, k;
    oe = '0; om = '0; z = 0; o = 0; u = 0; lat = 1;
    if (mt == 0) begin
      z = 1;
    end else if (mt[8]) begin
      oe = ex + 8'd1;
      if (oe == 8'hFF) o = 1;
      else begin
        tmp = mt >> 1;
        om  = tmp[6:0];
      end
    end else if (ex == 0) begin
      u = 1; z = 1;
    end else begin
      p = 7;
      while (mt[p] == 1'b0) p--;
      k = 7 - p;
      if (k >= int'(ex)) begin
        u = 1; z = 1;
        lat = int'(ex) + 1;
      end else begin
        oe  = ex - 8'(k);
        tmp = mt << k;
        om  = tmp[6:0];
        lat = 2 + k;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic sg, input logic [7:0] ex,
                        input logic [8:0] mt, input int stall);
    logic [7:0] ee; logic [6:0] em; logic ez, eo, eu; int elat;
    int lat; bit done;
    model(ex, mt, ee, em, ez, eo, eu, elat);
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; in_sign = sg; in_exp = ex; in_mant = mt;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; done = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) done = 1;
    end
    chk({tag, "_latency"}, lat, elat);
    if (done) begin
      for (int i = 0; i <= stall; i++) begin
        if (i > 0) @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_in_ready_busy"}, in_ready, 0);
        chk({tag, "_sign"}, out_sign, sg);
        chk({tag, "_exp"}, out_exp, ee);
        chk({tag, "_mant"}, out_mant, em);
        chk({tag, "_flags"}, {out_zero, out_ovf, out_unf}, {ez, eo, eu});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_consumed_valid"}, out_valid, 0);
      chk({tag, "_consumed_ready"}, in_ready, 1);
    end
  endtask

  initial begin
    logic [8:0] rm;
    logic [7:0] re;
    int mode;
    #12;
    chk("reset_valid", out_valid, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_data", {out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("no_shift",  1'b0, 8'h80, 9'h0A0, 0);
    run_op("carry",     1'b1, 8'h80, 9'h1C2, 0);
    run_op("six_zeros", 1'b0, 8'h80, 9'h003, 0);
    run_op("ovf",       1'b0, 8'hFE, 9'h180, 0);
    run_op("zero",      1'b1, 8'h55, 9'h000, 0);
    run_op("unf_shift", 1'b0, 8'h02, 9'h010, 0);
    run_op("unf_exp0",  1'b1, 8'h00, 9'h040, 0);
    run_op("exp1_ok",   1'b0, 8'h01, 9'h0FF, 0);
    run_op("stall",     1'b1, 8'h40, 9'h021, 3);

    // Reset asserted while the operand is still being shifted.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'h80; in_mant = 9'h003;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_shift_busy", in_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_data", {out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("after_rst", 1'b0, 8'h10, 9'h05A, 0);

    for (int n = 0; n < 60; n++) begin
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        rm = 9'($urandom_range(0, 511));
        re = 8'($urandom_range(0, 255));
      end else begin
        rm = 9'($urandom_range(1, 255) >> $urandom_range(0, 7));
        re = (mode == 3) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 255));
      end
      run_op("rand", 1'($urandom_range(0, 1)), re, rm, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
